// File: rtl/scratch_mem_arbiter.sv
// Arbiter for the single-ported scratch RAM shared by the stack sequencer, execute LD/ST port and debug port.
// Provides locked multi-beat ownership, debug anti-starvation and tagged one-cycle read-data return.
module scratch_mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned LOCK_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stk_req,
  input  logic              ex_req,
  input  logic              dbg_req,
  input  logic              stk_we,
  input  logic              ex_we,
  input  logic              dbg_we,
  input  logic              stk_lock,
  input  logic              ex_lock,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] stk_addr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stk_gnt,
  output logic              ex_gnt,
  output logic              dbg_gnt,
  output logic              stk_rvalid,
  output logic              ex_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ex_stall
);

  localparam int unsigned LCNT_W = ($clog2(LOCK_MAX) + 1 > 3) ? $clog2(LOCK_MAX) + 1 : 3;
  localparam int unsigned SCNT_W = 8;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_STK = 2'd0;
  localparam logic [SEL_W-1:0] SEL_EX  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_DBG = 2'd2;

  typedef enum logic [1:0] {ARB, OWN_STK, OWN_EX, OWN_DBG} state_e;

  state_e              state_q, state_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [SCNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [SEL_W-1:0]    rd_tag_q, rd_tag_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                gnt_any;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    owner;
  logic                owner_req;
  logic                owner_lock;
  logic                sel_we;
  logic                sel_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration, payload mux and lock state machine next-state.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    sel        = SEL_STK;
    gnt_any    = 1'b0;
    owner      = SEL_STK;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    sel_addr   = stk_addr;
    sel_wdata  = stk_wdata;

    case (state_q)
      OWN_STK: begin owner = SEL_STK; owner_req = stk_req; owner_lock = stk_lock; end
      OWN_EX:  begin owner = SEL_EX;  owner_req = ex_req;  owner_lock = ex_lock;  end
      OWN_DBG: begin owner = SEL_DBG; owner_req = dbg_req; owner_lock = dbg_lock; end
      default: ;
    endcase

    if (owner_req) begin
      sel     = owner;
      gnt_any = 1'b1;
    end else if (dbg_req && (starve_cnt_q == SCNT_W'(STARVE_LIMIT))) begin
      sel     = SEL_DBG;
      gnt_any = 1'b1;
    end else if (stk_req) begin
      sel     = SEL_STK;
      gnt_any = 1'b1;
    end else if (ex_req) begin
      sel     = SEL_EX;
      gnt_any = 1'b1;
    end else if (dbg_req) begin
      sel     = SEL_DBG;
      gnt_any = 1'b1;
    end

    if (!reset_n) begin
      gnt_any = 1'b0;
    end

    case (sel)
      SEL_EX:  begin sel_we = ex_we;  sel_lock = ex_lock;  sel_addr = ex_addr;  sel_wdata = ex_wdata;  end
      SEL_DBG: begin sel_we = dbg_we; sel_lock = dbg_lock; sel_addr = dbg_addr; sel_wdata = dbg_wdata; end
      default: begin sel_we = stk_we; sel_lock = stk_lock; sel_addr = stk_addr; sel_wdata = stk_wdata; end
    endcase

    // An owner still requesting keeps the lock until it drops lock or hits LOCK_MAX beats.
    if (owner_req) begin
      if (owner_lock && (lock_cnt_q < LCNT_W'(LOCK_MAX - 1))) begin
        lock_cnt_d = lock_cnt_q + LCNT_W'(1);
      end else begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = ARB;
      lock_cnt_d = '0;
      if (gnt_any && sel_lock && (LOCK_MAX > 1)) begin
        lock_cnt_d = LCNT_W'(1);
        case (sel)
          SEL_EX:  state_d = OWN_EX;
          SEL_DBG: state_d = OWN_DBG;
          default: state_d = OWN_STK;
        endcase
      end
    end
  end

  assign stk_gnt = gnt_any && (sel == SEL_STK);
  assign ex_gnt  = gnt_any && (sel == SEL_EX);
  assign dbg_gnt = gnt_any && (sel == SEL_DBG);

  // Debug starvation counter saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || dbg_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SCNT_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SCNT_W'(1);
    end
  end

  assign rd_pend_d = gnt_any && !sel_we;
  assign rd_tag_d  = gnt_any ? sel : rd_tag_q;

  assign mem_we    = gnt_any && sel_we;
  assign mem_addr  = gnt_any ? sel_addr  : addr_q;
  assign mem_wdata = gnt_any ? sel_wdata : wdata_q;

  assign stk_rvalid = reset_n && rd_pend_q && (rd_tag_q == SEL_STK);
  assign ex_rvalid  = reset_n && rd_pend_q && (rd_tag_q == SEL_EX);
  assign dbg_rvalid = reset_n && rd_pend_q && (rd_tag_q == SEL_DBG);
  assign rdata      = mem_rdata;
  assign ex_stall   = reset_n && ex_req && !ex_gnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= SEL_STK;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
      addr_q       <= mem_addr;
      wdata_q      <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Directed bench for scratch_mem_arbiter with a behavioural one-cycle-latency RAM model.
module tb_scratch_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 10;

  logic              clk;
  logic              reset_n;
  logic              stk_req, ex_req, dbg_req;
  logic              stk_we, ex_we, dbg_we;
  logic              stk_lock, ex_lock, dbg_lock;
  logic [ADDR_W-1:0] stk_addr, ex_addr, dbg_addr;
  logic [DATA_W-1:0] stk_wdata, ex_wdata, dbg_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stk_gnt, ex_gnt, dbg_gnt;
  logic              stk_rvalid, ex_rvalid, dbg_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              ex_stall;

  int checks = 0;
  int errors = 0;

  scratch_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(15), .LOCK_MAX(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .stk_req(stk_req), .ex_req(ex_req), .dbg_req(dbg_req),
    .stk_we(stk_we), .ex_we(ex_we), .dbg_we(dbg_we),
    .stk_lock(stk_lock), .ex_lock(ex_lock), .dbg_lock(dbg_lock),
    .stk_addr(stk_addr), .ex_addr(ex_addr), .dbg_addr(dbg_addr),
    .stk_wdata(stk_wdata), .ex_wdata(ex_wdata), .dbg_wdata(dbg_wdata),
    .mem_rdata(mem_rdata),
    .stk_gnt(stk_gnt), .ex_gnt(ex_gnt), .dbg_gnt(dbg_gnt),
    .stk_rvalid(stk_rvalid), .ex_rvalid(ex_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .ex_stall(ex_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'((a * 37) ^ 'h2A5);
  endfunction

  // RAM model: unwritten words read back their init pattern.
  logic [DATA_W-1:0] ram [256];
  logic [255:0]      written;
  always @(posedge clk) begin
    if (!reset_n) begin
      written <= '0;
    end else if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stk_req = 1'b0; ex_req = 1'b0; dbg_req = 1'b0;
    stk_we = 1'b0; ex_we = 1'b0; dbg_we = 1'b0;
    stk_lock = 1'b0; ex_lock = 1'b0; dbg_lock = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    stk_req = 1'b1; ex_req = 1'b1; dbg_req = 1'b1; stk_we = 1'b1;
    stk_addr = 8'h20; stk_wdata = 10'h123;
    ex_addr = '0; ex_wdata = '0; dbg_addr = '0; dbg_wdata = '0;

    repeat (2) begin
      @(negedge clk); #1;
      check("rst_stk_gnt", 32'(stk_gnt), 0);
      check("rst_ex_gnt", 32'(ex_gnt), 0);
      check("rst_dbg_gnt", 32'(dbg_gnt), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_rvalid", 32'({stk_rvalid, ex_rvalid, dbg_rvalid}), 0);
      check("rst_ex_stall", 32'(ex_stall), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
    end

    @(negedge clk); reset_n = 1'b1; #1;
    check("rel_stk_gnt", 32'(stk_gnt), 1);
    check("rel_ex_gnt", 32'(ex_gnt), 0);
    check("rel_ex_stall", 32'(ex_stall), 1);
    check("rel_mem_we", 32'(mem_we), 1);
    check("rel_mem_addr", 32'(mem_addr), 'h20);

    @(negedge clk); idle(); #1;
    check("hold_mem_addr", 32'(mem_addr), 'h20);
    check("hold_mem_wdata", 32'(mem_wdata), 'h123);
    check("hold_mem_we", 32'(mem_we), 0);

    // Execute read alone, then stk/ex collision with ex read data returning.
    @(negedge clk); ex_req = 1'b1; ex_addr = 8'h10; #1;
    check("exrd_gnt", 32'(ex_gnt), 1);
    check("exrd_addr", 32'(mem_addr), 'h10);
    check("exrd_we", 32'(mem_we), 0);

    @(negedge clk); idle();
    stk_req = 1'b1; stk_addr = 8'h11; ex_req = 1'b1; ex_addr = 8'h12; #1;
    check("exrd_rvalid", 32'(ex_rvalid), 1);
    check("exrd_rdata", 32'(rdata), 32'(init_val('h10)));
    check("coll_stk_gnt", 32'(stk_gnt), 1);
    check("coll_ex_gnt", 32'(ex_gnt), 0);
    check("coll_ex_stall", 32'(ex_stall), 1);

    @(negedge clk); idle(); #1;
    check("stkrd_rvalid", 32'(stk_rvalid), 1);
    check("stkrd_ex_rvalid", 32'(ex_rvalid), 0);
    check("stkrd_rdata", 32'(rdata), 32'(init_val('h11)));

    // Locked two-beat interrupt push with execute waiting.
    @(negedge clk);
    stk_req = 1'b1; stk_we = 1'b1; stk_lock = 1'b1; stk_addr = 8'hFF; stk_wdata = 10'h3FF;
    ex_req = 1'b1; ex_addr = 8'h30; #1;
    check("push1_stk_gnt", 32'(stk_gnt), 1);
    check("push1_ex_gnt", 32'(ex_gnt), 0);
    check("push1_addr", 32'(mem_addr), 'hFF);
    check("push1_wdata", 32'(mem_wdata), 'h3FF);
    check("push1_we", 32'(mem_we), 1);

    @(negedge clk); stk_lock = 1'b0; stk_addr = 8'hFE; stk_wdata = 10'h005; #1;
    check("push2_stk_gnt", 32'(stk_gnt), 1);
    check("push2_ex_gnt", 32'(ex_gnt), 0);
    check("push2_wdata", 32'(mem_wdata), 'h005);

    @(negedge clk); stk_req = 1'b0; stk_we = 1'b0; #1;
    check("push3_ex_gnt", 32'(ex_gnt), 1);

    @(negedge clk); idle(); dbg_req = 1'b1; dbg_addr = 8'hFF; #1;
    check("push_ex_rvalid", 32'(ex_rvalid), 1);
    check("push_ex_rdata", 32'(rdata), 32'(init_val('h30)));
    check("rb_dbg_gnt", 32'(dbg_gnt), 1);

    @(negedge clk); dbg_addr = 8'hFE; #1;
    check("rb_ff_rvalid", 32'(dbg_rvalid), 1);
    check("rb_ff_rdata", 32'(rdata), 'h3FF);

    @(negedge clk); idle(); #1;
    check("rb_fe_rvalid", 32'(dbg_rvalid), 1);
    check("rb_fe_rdata", 32'(rdata), 'h005);

    // Stack holds lock for six cycles; it keeps winning on priority after LOCK_MAX.
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); idle();
      stk_req = 1'b1; stk_lock = 1'b1; stk_addr = 8'h40; ex_req = 1'b1; #1;
      check($sformatf("stklk%0d_stk_gnt", c), 32'(stk_gnt), 1);
      check($sformatf("stklk%0d_ex_gnt", c), 32'(ex_gnt), 0);
    end
    @(negedge clk); idle(); #1;

    // Execute owns the lock; the stack is shut out until LOCK_MAX beats are done.
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); idle();
      ex_req = 1'b1; ex_lock = 1'b1; dbg_req = 1'b1; stk_req = (c >= 2); #1;
      check($sformatf("exlk%0d_ex_gnt", c), 32'(ex_gnt), (c <= 4) ? 1 : 0);
      check($sformatf("exlk%0d_stk_gnt", c), 32'(stk_gnt), (c <= 4) ? 0 : 1);
      check($sformatf("exlk%0d_dbg_gnt", c), 32'(dbg_gnt), 0);
    end
    @(negedge clk); idle(); dbg_req = 1'b1; #1;
    check("exlk6_dbg_gnt", 32'(dbg_gnt), 1);

    // Debug starvation: forced through on the 16th denied-then-granted cycle.
    @(negedge clk); idle(); #1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk); idle();
      stk_req = 1'b1; stk_addr = 8'h50; dbg_req = 1'b1; dbg_addr = 8'h60; #1;
      check($sformatf("starve%0d_dbg_gnt", c), 32'(dbg_gnt), (c == 16) ? 1 : 0);
      check($sformatf("starve%0d_stk_gnt", c), 32'(stk_gnt), (c == 16) ? 0 : 1);
    end

    // Reset in the middle of a locked read.
    @(negedge clk); idle(); stk_req = 1'b1; stk_lock = 1'b1; stk_addr = 8'h10; #1;
    check("midrst_stk_gnt", 32'(stk_gnt), 1);

    @(negedge clk); reset_n = 1'b0; #1;
    check("midrst_rvalid_a", 32'(stk_rvalid), 0);
    check("midrst_gnt_a", 32'(stk_gnt), 0);

    @(negedge clk); #1;
    check("midrst_rvalid_b", 32'(stk_rvalid), 0);
    check("midrst_mem_addr", 32'(mem_addr), 0);

    @(negedge clk); reset_n = 1'b1; idle(); ex_req = 1'b1; ex_addr = 8'h10; #1;
    check("postrst_ex_gnt", 32'(ex_gnt), 1);
    check("postrst_stk_rvalid", 32'(stk_rvalid), 0);

    @(negedge clk); idle(); #1;
    check("postrst_ex_rvalid", 32'(ex_rvalid), 1);
    check("postrst_ex_rdata", 32'(rdata), 32'(init_val('h10)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
